wb_retire_monitor: RTL and testbench
====================================

# wb_retire_monitor

Retirement monitor attached to the writeback-stage outputs of `riscv_pipeline` (`wb_reg_write_wb_stage`, `wb_rd_wb_stage`, `wb_result_wb_stage`) and to `branch_taken_ex_stage`. It keeps a shadow architectural register file, records every committed register write in a first-word-fall-through trace FIFO drained by a pop handshake, and keeps saturating cycle, retire and taken-branch counters. Benches and on-chip debug logic use it to check architectural state without probing pipeline internals.

## Interface
- `DEPTH`, 16, trace FIFO entries; power of two, ≥2.
- `CNT_W`, 32, counter width.
- `PTR_W`, $clog2(DEPTH), derived; not overridden.

- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `count_en` in 1: counters advance only when high.
- `wb_reg_write` in 1: writeback write-enable from WB stage.
- `wb_rd` in 5: writeback destination register.
- `wb_result` in 32: writeback data.
- `branch_taken` in 1: EX-stage taken-branch/jump strobe, one cycle per event.
- `trace_pop` in 1: consumer removes the head entry.
- `trace_valid` out 1: FIFO non-empty; head outputs are meaningful.
- `trace_rd` out 5: head entry destination register.
- `trace_data` out 32: head entry data.
- `trace_count` out PTR_W+1: occupancy, 0..DEPTH.
- `trace_overflow` out 1: sticky flag, set when a commit is dropped.
- `overflow_clr` in 1: clears `trace_overflow`.
- `query_addr` in 5: shadow register file read address.
- `query_data` out 32: registered shadow register value.
- `cycle_count` out CNT_W: cycles with `count_en` high.
- `retire_count` out CNT_W: commits (see Operation).
- `branch_count` out CNT_W: taken branches.

## Operation
- Commit: `commit = wb_reg_write && (wb_rd != 0)`. Writes to x0 are ignored everywhere.
- Shadow register file: 32×32; on commit `shadow[wb_rd] <= wb_result`. x0 reads 0. Not cleared by reset; every entry is zeroed by a reset sweep (see Timing).
- Query: `query_data <= (query_addr==0) ? 0 : (commit && wb_rd==query_addr) ? wb_result : shadow[query_addr]` (write-through bypass).
- FIFO push on commit with entry {wb_rd, wb_result}; pop when `trace_pop && trace_valid`.
  - Empty: `trace_pop` is ignored; a simultaneous push is accepted.
  - Full, push without pop: entry dropped, `trace_overflow` <= 1, FIFO unchanged.
  - Full, push with pop: both happen, occupancy stays DEPTH, no overflow.
  - Pointers wrap modulo DEPTH; occupancy is a separate PTR_W+1 counter.
- `trace_overflow`: set has priority over `overflow_clr` in the same cycle.
- Counters (when `count_en`): `cycle_count` +1 every cycle; `retire_count` +1 per commit; `branch_count` +1 when `branch_taken`. Each saturates at 2^CNT_W−1 and never wraps.

## Timing
- Reset (`reset`==0 at a rising edge): pointers, occupancy, counters, `trace_overflow`, `query_data` go to 0; `trace_valid`=0; `trace_rd`/`trace_data` = 0 while empty. Reset mid-operation discards all FIFO contents in that cycle.
- Reset sweep: the first 32 cycles after `reset` rises zero shadow[0..31] in order, one per cycle. A commit during the sweep takes priority over the sweep write to the same index. `query_data` is valid only after the sweep.
- Push-to-visible latency: 1 cycle (entry on `trace_rd`/`trace_data`, `trace_valid` high on the cycle after the commit edge).
- Pop: head advances at the edge where `trace_pop && trace_valid`; the next entry is visible the following cycle.
- Query latency: 1 cycle.
- Counter latency: 1 cycle; all outputs registered except `trace_valid`/`trace_rd`/`trace_data`, which decode registered state.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with commits active -> all counters 0, `trace_valid`=0, `trace_count`=0; 33 cycles later `query_addr`=5 gives 0.
- Basic commit: commit x5=0x0000_00AA, then x0=0xFFFF_FFFF -> `trace_count`=1, head {5, 0xAA}; `retire_count`=1; query x5 gives 0xAA, query x0 gives 0.
- Fill/overflow: DEPTH+1 commits with no pop -> `trace_count`=16, `trace_overflow`=1, head = first entry; `overflow_clr` pulse -> flag 0.
- Full with simultaneous push/pop: at 16 entries push x7=0x1234 while popping -> count stays 16, no overflow, tail = {7, 0x1234} after 15 further pops.
- Bypass and wrap: commit x3=0x55 while `query_addr`=3 -> `query_data`=0x55 next cycle; push/pop 40 entries in sequence -> FIFO order preserved across pointer wrap.
- Counters: `branch_taken` pulsed 3 times with `count_en`=1, once with `count_en`=0 -> `branch_count`=3; preload CNT_W=4 variant to 15 -> stays 15.

Source files
------------

// File: rtl/wb_retire_monitor_if.sv
// Trace FIFO head/pop handshake between the retirement monitor and its consumer.
// The monitor drives the head entry; the consumer acknowledges it with trace_pop.
interface wb_retire_monitor_if;
    logic        trace_valid;
    logic [4:0]  trace_rd;
    logic [31:0] trace_data;
    logic        trace_pop;

    modport master (
        output trace_valid,
        output trace_rd,
        output trace_data,
        input  trace_pop
    );

    modport slave (
        input  trace_valid,
        input  trace_rd,
        input  trace_data,
        output trace_pop
    );
endinterface

// File: rtl/wb_retire_monitor.sv
// Writeback retirement monitor: shadow register file, commit trace FIFO and
// saturating cycle/retire/branch counters.
module wb_retire_monitor #(
    parameter  int DEPTH = 16,
    parameter  int CNT_W = 32,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       count_en,
    input  logic                       wb_reg_write,
    input  logic [4:0]                 wb_rd,
    input  logic [31:0]                wb_result,
    input  logic                       branch_taken,
    wb_retire_monitor_if.master        trace,
    output logic [PTR_W:0]             trace_count,
    output logic                       trace_overflow,
    input  logic                       overflow_clr,
    input  logic [4:0]                 query_addr,
    output logic [31:0]                query_data,
    output logic [CNT_W-1:0]           cycle_count,
    output logic [CNT_W-1:0]           retire_count,
    output logic [CNT_W-1:0]           branch_count
);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } trace_entry_t;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic                 commit;
    logic                 pop;
    logic                 full;
    logic                 push;
    logic                 drop;

    logic [31:0]          shadow_q [32];
    logic [31:0]          shadow_d [32];
    logic                 sweep_active_q, sweep_active_d;
    logic [4:0]           sweep_idx_q, sweep_idx_d;

    trace_entry_t         mem_q [DEPTH];
    trace_entry_t         mem_d [DEPTH];
    trace_entry_t         head;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       count_q, count_d;
    logic                 overflow_q, overflow_d;

    logic [31:0]          query_q, query_d;
    logic [CNT_W-1:0]     cycle_q, cycle_d;
    logic [CNT_W-1:0]     retire_q, retire_d;
    logic [CNT_W-1:0]     branch_q, branch_d;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             inc
    );
        return (inc && v != CNT_MAX) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        commit = wb_reg_write && (wb_rd != 5'd0);
        full   = (count_q == FULL_CNT);
        pop    = trace.trace_pop && (count_q != '0);
        push   = commit && (!full || pop);
        drop   = commit && full && !pop;
    end

    // Sweep clears the shadow file after reset; a same-index commit wins.
    always_comb begin
        shadow_d       = shadow_q;
        sweep_active_d = sweep_active_q && (sweep_idx_q != 5'd31);
        sweep_idx_d    = sweep_active_q ? sweep_idx_q + 5'd1 : sweep_idx_q;
        if (reset) begin
            if (sweep_active_q) begin
                shadow_d[sweep_idx_q] = '0;
            end
            if (commit) begin
                shadow_d[wb_rd] = wb_result;
            end
        end
    end

    always_comb begin
        if (query_addr == 5'd0) begin
            query_d = '0;
        end else if (commit && wb_rd == query_addr) begin
            query_d = wb_result;
        end else begin
            query_d = shadow_q[query_addr];
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{rd: wb_rd, data: wb_result};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        cycle_d  = sat_inc(cycle_q,  count_en);
        retire_d = sat_inc(retire_q, count_en && commit);
        branch_d = sat_inc(branch_q, count_en && branch_taken);
    end

    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
        mem_q    <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sweep_active_q <= 1'b1;
            sweep_idx_q    <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            query_q        <= '0;
            cycle_q        <= '0;
            retire_q       <= '0;
            branch_q       <= '0;
        end else begin
            sweep_active_q <= sweep_active_d;
            sweep_idx_q    <= sweep_idx_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            overflow_q     <= overflow_d;
            query_q        <= query_d;
            cycle_q        <= cycle_d;
            retire_q       <= retire_d;
            branch_q       <= branch_d;
        end
    end

    always_comb begin
        head              = mem_q[rd_ptr_q];
        trace.trace_valid = (count_q != '0);
        trace.trace_rd    = trace.trace_valid ? head.rd   : '0;
        trace.trace_data  = trace.trace_valid ? head.data : '0;
    end

    assign trace_count    = count_q;
    assign trace_overflow = overflow_q;
    assign query_data     = query_q;
    assign cycle_count    = cycle_q;
    assign retire_count   = retire_q;
    assign branch_count   = branch_q;

endmodule

// File: tb/tb_wb_retire_monitor.sv
// Directed bench for wb_retire_monitor, with a narrow-counter instance
// to exercise saturation.
module tb_wb_retire_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        count_en = 1'b0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_result = '0;
    logic        branch_taken = 1'b0;
    logic        trace_pop = 1'b0;
    logic        overflow_clr = 1'b0;
    logic [4:0]  query_addr = '0;

    logic [4:0]  trace_count;
    logic        trace_overflow;
    logic [31:0] query_data;
    logic [31:0] cycle_count, retire_count, branch_count;

    logic [4:0]  s_trace_count;
    logic        s_trace_overflow;
    logic [31:0] s_query_data;
    logic [3:0]  s_cycle_count, s_retire_count, s_branch_count;

    int tests = 0;
    int fails = 0;

    wb_retire_monitor_if tr_if ();
    wb_retire_monitor_if sm_if ();

    assign tr_if.trace_pop = trace_pop;
    assign sm_if.trace_pop = trace_pop;

    always #5 clk = ~clk;

    wb_retire_monitor #(.DEPTH(16), .CNT_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .count_en       (count_en),
        .wb_reg_write   (wb_reg_write),
        .wb_rd          (wb_rd),
        .wb_result      (wb_result),
        .branch_taken   (branch_taken),
        .trace          (tr_if.master),
        .trace_count    (trace_count),
        .trace_overflow (trace_overflow),
        .overflow_clr   (overflow_clr),
        .query_addr     (query_addr),
        .query_data     (query_data),
        .cycle_count    (cycle_count),
        .retire_count   (retire_count),
        .branch_count   (branch_count)
    );

    wb_retire_monitor #(.DEPTH(16), .CNT_W(4)) u_small (
        .clk            (clk),
        .reset          (reset),
        .count_en       (count_en),
        .wb_reg_write   (wb_reg_write),
        .wb_rd          (wb_rd),
        .wb_result      (wb_result),
        .branch_taken   (branch_taken),
        .trace          (sm_if.master),
        .trace_count    (s_trace_count),
        .trace_overflow (s_trace_overflow),
        .overflow_clr   (overflow_clr),
        .query_addr     (query_addr),
        .query_data     (s_query_data),
        .cycle_count    (s_cycle_count),
        .retire_count   (s_retire_count),
        .branch_count   (s_branch_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset held with commits active
        count_en     = 1'b1;
        wb_reg_write = 1'b1;
        wb_rd        = 5'd9;
        wb_result    = 32'hDEAD_BEEF;
        query_addr   = 5'd5;
        tick();
        tick();
        chk("rst_cycle", cycle_count, 0);
        chk("rst_retire", retire_count, 0);
        chk("rst_branch", branch_count, 0);
        chk("rst_valid", tr_if.trace_valid, 0);
        chk("rst_count", trace_count, 0);
        chk("rst_rd", tr_if.trace_rd, 0);
        chk("rst_data", tr_if.trace_data, 0);
        chk("rst_ovf", trace_overflow, 0);

        reset        = 1'b1;
        wb_reg_write = 1'b0;
        repeat (33) tick();
        chk("sweep_q5", query_data, 0);
        chk("cycle_33", cycle_count, 33);
        chk("small_cyc_sat", s_cycle_count, 15);

        // basic commit, then x0 write ignored
        wb_reg_write = 1'b1;
        wb_rd        = 5'd5;
        wb_result    = 32'h0000_00AA;
        tick();
        chk("bypass_x5", query_data, 32'hAA);
        wb_rd     = 5'd0;
        wb_result = 32'hFFFF_FFFF;
        tick();
        wb_reg_write = 1'b0;
        chk("basic_count", trace_count, 1);
        chk("basic_rd", tr_if.trace_rd, 5);
        chk("basic_data", tr_if.trace_data, 32'hAA);
        chk("basic_retire", retire_count, 1);
        query_addr = 5'd0;
        tick();
        chk("query_x0", query_data, 0);
        query_addr = 5'd5;
        tick();
        chk("query_x5", query_data, 32'hAA);
        trace_pop = 1'b1;
        tick();
        trace_pop = 1'b0;
        chk("pop_empty_cnt", trace_count, 0);
        chk("pop_empty_vld", tr_if.trace_valid, 0);
        trace_pop = 1'b1;
        tick();
        trace_pop = 1'b0;
        chk("pop_on_empty", trace_count, 0);

        // fill past full
        wb_reg_write = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wb_rd     = 5'(i % 30 + 1);
            wb_result = 32'h100 + 32'(i);
            tick();
        end
        wb_reg_write = 1'b0;
        chk("full_count", trace_count, 16);
        chk("full_ovf", trace_overflow, 1);
        chk("full_head_rd", tr_if.trace_rd, 1);
        chk("full_head_data", tr_if.trace_data, 32'h100);
        chk("full_retire", retire_count, 18);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("ovf_clr", trace_overflow, 0);

        // full with simultaneous push and pop
        wb_reg_write = 1'b1;
        wb_rd        = 5'd7;
        wb_result    = 32'h1234;
        trace_pop    = 1'b1;
        tick();
        wb_reg_write = 1'b0;
        trace_pop    = 1'b0;
        chk("pp_count", trace_count, 16);
        chk("pp_ovf", trace_overflow, 0);
        chk("pp_head", tr_if.trace_data, 32'h101);
        trace_pop = 1'b1;
        repeat (15) tick();
        trace_pop = 1'b0;
        chk("tail_count", trace_count, 1);
        chk("tail_rd", tr_if.trace_rd, 7);
        chk("tail_data", tr_if.trace_data, 32'h1234);
        trace_pop = 1'b1;
        tick();
        trace_pop = 1'b0;
        chk("drain", trace_count, 0);

        // write-through bypass
        query_addr   = 5'd3;
        wb_reg_write = 1'b1;
        wb_rd        = 5'd3;
        wb_result    = 32'h55;
        tick();
        wb_reg_write = 1'b0;
        chk("bypass_x3", query_data, 32'h55);
        trace_pop = 1'b1;
        tick();
        trace_pop = 1'b0;

        // order across pointer wrap
        for (int i = 0; i < 40; i++) begin
            wb_reg_write = 1'b1;
            wb_rd        = 5'(i % 31 + 1);
            wb_result    = 32'hA000 + 32'(i);
            tick();
            wb_reg_write = 1'b0;
            chk("wrap_rd", tr_if.trace_rd, 32'(i % 31 + 1));
            chk("wrap_data", tr_if.trace_data, 32'hA000 + 32'(i));
            trace_pop = 1'b1;
            tick();
            trace_pop = 1'b0;
        end
        chk("wrap_empty", trace_count, 0);
        chk("wrap_retire", retire_count, 60);

        // branch counter and count_en gating
        for (int i = 0; i < 3; i++) begin
            branch_taken = 1'b1;
            tick();
            branch_taken = 1'b0;
            tick();
        end
        count_en     = 1'b0;
        branch_taken = 1'b1;
        wb_reg_write = 1'b1;
        wb_rd        = 5'd4;
        wb_result    = 32'h4;
        tick();
        branch_taken = 1'b0;
        wb_reg_write = 1'b0;
        chk("branch_3", branch_count, 3);
        chk("retire_gated", retire_count, 60);
        chk("small_ret_sat", s_retire_count, 15);
        chk("small_br", s_branch_count, 3);
        chk("small_cyc_hold", s_cycle_count, 15);

        // reset mid-operation discards contents
        count_en = 1'b1;
        chk("pre_rst_count", trace_count, 1);
        reset = 1'b0;
        tick();
        chk("mid_rst_count", trace_count, 0);
        chk("mid_rst_valid", tr_if.trace_valid, 0);
        chk("mid_rst_branch", branch_count, 0);
        chk("mid_rst_query", query_data, 0);
        reset = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
